// File: rtl/spi_master_ctrl_pkg.sv
// Shared constants, frame layout and FSM encoding for the SPI master that drives
// the LED-control slave.
package spi_master_ctrl_pkg;

  localparam int unsigned MASTER_FRAME_WIDTH = 24;
  localparam int unsigned BRIGHTNESS_WIDTH   = 8;
  localparam int unsigned CMD_WIDTH          = 8;
  localparam int unsigned SPIM_BIT_CNT_W     = 6;
  localparam int unsigned MASTER_CLK_NS      = 8;
  localparam int unsigned SLAVE_CLK_NS       = 10;

  localparam logic [CMD_WIDTH-1:0] CMD_NOP      = 8'h00;
  localparam logic [CMD_WIDTH-1:0] CMD_LED_SET  = 8'h01;
  localparam logic [CMD_WIDTH-1:0] CMD_LED_READ = 8'h02;
  localparam logic [7:0]           ADDR_NONE    = 8'h00;
  localparam logic [7:0]           PAYLOAD_NONE = 8'h00;

  typedef struct packed {
    logic [CMD_WIDTH-1:0] cmd;
    logic [7:0]           addr;
    logic [7:0]           payload;
  } spi_frame_t;

  typedef enum logic [2:0] {
    SPIM_IDLE  = 3'd0,
    SPIM_SETUP = 3'd1,
    SPIM_SHIFT = 3'd2,
    SPIM_HOLD  = 3'd3,
    SPIM_GAP   = 3'd4
  } spim_state_e;

  // Read frames get a response byte clocked back after the command bits.
  function automatic logic is_read_cmd(input logic [CMD_WIDTH-1:0] cmd);
    return cmd == CMD_LED_READ;
  endfunction

endpackage

// File: rtl/spi_master_ctrl_sclk_gen.sv
// SPI clock divider: sclk toggles every CLK_DIV sysclk cycles while enabled and
// idles low; rise_evt/fall_evt are high in the cycle whose closing edge moves sclk.
module spi_master_ctrl_sclk_gen #(
  parameter int unsigned CLK_DIV = 3
) (
  input  logic sysclk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic rise_evt,
  output logic fall_evt
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic             last_phase_next;

  // Strobes are registered one cycle early so the controller acts on the same
  // edge that moves sclk; this needs CLK_DIV >= 2.
  assign last_phase_next = (div_cnt == DIV_W'(CLK_DIV - 2));

  always_ff @(posedge sysclk) begin
    if (rst || !en) begin
      div_cnt  <= '0;
      sclk     <= 1'b0;
      rise_evt <= 1'b0;
      fall_evt <= 1'b0;
    end else begin
      if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
        div_cnt <= '0;
        sclk    <= ~sclk;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      rise_evt <= last_phase_next && !sclk;
      fall_evt <= last_phase_next && sclk;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// Mode-0 MSB-first SPI master for the LED-control slave; read frames append a
// response byte returned on o_frame. Optional SPI_MASTER_DEBUG_EN exposes internals.
module spi_master_ctrl
  import spi_master_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 3,
  parameter int unsigned FRAME_WIDTH  = MASTER_FRAME_WIDTH,
  parameter int unsigned RESP_WIDTH   = BRIGHTNESS_WIDTH,
  parameter int unsigned CS_SETUP_CYC = 2,
  parameter int unsigned CS_HOLD_CYC  = 2,
  parameter int unsigned CS_IDLE_CYC  = 4
) (
  input  logic                   sysclk,
  input  logic                   rst,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [FRAME_WIDTH-1:0] i_frame,
  output logic                   o_done,
  output logic [RESP_WIDTH-1:0]  o_frame,
  output logic                   cs,
  output logic                   sclk,
  output logic                   mosi,
  input  logic                   miso
`ifdef SPI_MASTER_DEBUG_EN
  ,
  output logic [FRAME_WIDTH-1:0]    o_m_shift_reg_debug,
  output logic [SPIM_BIT_CNT_W-1:0] o_m_bit_cnt_debug,
  output logic [2:0]                o_m_state_debug
`endif
);

  localparam int unsigned BIT_W  = SPIM_BIT_CNT_W;
  localparam int unsigned PH_MAX =
    (CS_SETUP_CYC > CS_HOLD_CYC) ?
      ((CS_SETUP_CYC > CS_IDLE_CYC) ? CS_SETUP_CYC : CS_IDLE_CYC) :
      ((CS_HOLD_CYC  > CS_IDLE_CYC) ? CS_HOLD_CYC  : CS_IDLE_CYC);
  localparam int unsigned CNT_W  = $clog2(PH_MAX + 1);

  spim_state_e            state;
  logic [CNT_W-1:0]       cnt;
  logic [BIT_W-1:0]       bit_cnt;
  logic [BIT_W-1:0]       nbits;
  logic [FRAME_WIDTH-1:0] tx_shift;
  logic [RESP_WIDTH-1:0]  rx_shift;
  logic                   is_read;
  logic                   shift_en;
  logic                   rise_evt;
  logic                   fall_evt;

  assign shift_en = (state == SPIM_SHIFT);
  assign nbits    = is_read ? BIT_W'(FRAME_WIDTH + RESP_WIDTH) : BIT_W'(FRAME_WIDTH);

  spi_master_ctrl_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .sysclk   (sysclk),
    .rst      (rst),
    .en       (shift_en),
    .sclk     (sclk),
    .rise_evt (rise_evt),
    .fall_evt (fall_evt)
  );

  // Frame sequencer: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      state    <= SPIM_GAP;
      cnt      <= '0;
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      is_read  <= 1'b0;
      cs       <= 1'b1;
      mosi     <= 1'b0;
      o_ready  <= 1'b0;
      o_done   <= 1'b0;
      o_frame  <= '0;
    end else begin
      o_done <= 1'b0;
      case (state)
        SPIM_IDLE: begin
          if (i_valid) begin
            tx_shift <= i_frame;
            is_read  <= is_read_cmd(i_frame[FRAME_WIDTH-1 -: CMD_WIDTH]);
            mosi     <= i_frame[FRAME_WIDTH-1];
            cs       <= 1'b0;
            o_ready  <= 1'b0;
            cnt      <= '0;
            bit_cnt  <= '0;
            state    <= SPIM_SETUP;
          end
        end

        SPIM_SETUP: begin
          if (cnt == CNT_W'(CS_SETUP_CYC - 1)) begin
            cnt   <= '0;
            state <= SPIM_SHIFT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        SPIM_SHIFT: begin
          if (rise_evt) begin
            rx_shift <= {rx_shift[RESP_WIDTH-2:0], miso};
            bit_cnt  <= bit_cnt + 1'b1;
          end
          if (fall_evt) begin
            tx_shift <= tx_shift << 1;
            // Response bits are clocked with mosi held low.
            mosi <= (bit_cnt < BIT_W'(FRAME_WIDTH)) ? tx_shift[FRAME_WIDTH-2] : 1'b0;
            if (bit_cnt == nbits) begin
              mosi  <= 1'b0;
              cnt   <= '0;
              state <= SPIM_HOLD;
            end
          end
        end

        SPIM_HOLD: begin
          if (cnt == CNT_W'(CS_HOLD_CYC - 1)) begin
            cnt    <= '0;
            cs     <= 1'b1;
            o_done <= 1'b1;
            if (is_read) begin
              o_frame <= rx_shift;
            end
            state <= SPIM_GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        SPIM_GAP: begin
          if (cnt == CNT_W'(CS_IDLE_CYC - 1)) begin
            cnt     <= '0;
            o_ready <= 1'b1;
            state   <= SPIM_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          cs      <= 1'b1;
          mosi    <= 1'b0;
          o_ready <= 1'b0;
          cnt     <= '0;
          state   <= SPIM_GAP;
        end
      endcase
    end
  end

`ifdef SPI_MASTER_DEBUG_EN
  assign o_m_shift_reg_debug = tx_shift;
  assign o_m_bit_cnt_debug   = bit_cnt;
  assign o_m_state_debug     = state;
`endif

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl with a behavioural mode-0 slave that returns
// a programmable response byte on read frames.
module tb_spi_master_ctrl;
  import spi_master_ctrl_pkg::*;

  localparam int HALF_NS = MASTER_CLK_NS / 2;

  logic        sysclk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic [23:0] i_frame;
  logic        o_done;
  logic [7:0]  o_frame;
  logic        cs;
  logic        sclk;
  logic        mosi;
  logic        miso = 1'b0;

  int errors = 0;
  int checks = 0;

  // Monitor state
  logic        prev_cs = 1'b1;
  logic        prev_sclk = 1'b0;
  int          low_run = 0;
  int          high_run = 0;
  int          rises = 0;
  int          rises_total = 0;
  int          done_cnt = 0;
  logic [31:0] cap = '0;
  int          last_low = 0;
  int          last_rises = 0;
  int          last_gap = 0;
  logic [31:0] last_cap = '0;

  // Slave model state
  logic [7:0]  resp = '0;
  logic        prev_sclk_s = 1'b0;
  int          falls_s = 0;

  always #(HALF_NS) sysclk = ~sysclk;

  spi_master_ctrl dut (
    .sysclk  (sysclk),
    .rst     (rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_frame (i_frame),
    .o_done  (o_done),
    .o_frame (o_frame),
    .cs      (cs),
    .sclk    (sclk),
    .mosi    (mosi),
    .miso    (miso)
  );

  // Frame monitor: per-frame sclk rises, mosi bits at rise, cs low/high run lengths.
  always @(negedge sysclk) begin
    if (prev_cs && !cs) begin
      last_gap = high_run;
      high_run = 0;
      low_run  = 0;
      rises    = 0;
      cap      = '0;
    end
    if (!prev_cs && cs) begin
      last_low   = low_run;
      last_rises = rises;
      last_cap   = cap;
    end
    if (cs) high_run++;
    else    low_run++;
    if (sclk && !prev_sclk) begin
      rises++;
      rises_total++;
      cap = {cap[30:0], mosi};
    end
    if (o_done) done_cnt++;
    prev_cs   = cs;
    prev_sclk = sclk;
  end

  // Mode-0 slave: after the 24th falling edge, shift out resp MSB first.
  always @(negedge sysclk) begin
    if (cs) begin
      falls_s = 0;
      miso    = 1'b0;
    end else if (!sclk && prev_sclk_s) begin
      falls_s++;
      if (falls_s >= 24 && falls_s < 32) miso = resp[31 - falls_s];
      else                               miso = 1'b0;
    end
    prev_sclk_s = sclk;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic start_frame(input logic [23:0] f);
    bit rdy = 1'b0;
    for (int i = 0; i < 50 && !rdy; i++) begin
      @(negedge sysclk);
      rdy = o_ready;
    end
    check("ready_wait", 32'(rdy), 1);
    i_frame = f;
    i_valid = 1'b1;
    @(negedge sysclk);
    i_valid = 1'b0;
    check("lat_cs", 32'(cs), 0);
    check("lat_mosi", 32'(mosi), 32'(f[23]));
  endtask

  task automatic wait_done(input logic [7:0] exp_ofr);
    bit seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge sysclk);
      seen = o_done;
    end
    check("done_seen", 32'(seen), 1);
    check("o_frame", 32'(o_frame), 32'(exp_ofr));
    @(negedge sysclk);
    check("done_pulse", 32'(o_done), 0);
  endtask

  task automatic wait_rises(input int n);
    int   cnt = 0;
    logic prev = sclk;
    for (int i = 0; i < 400 && cnt < n; i++) begin
      @(negedge sysclk);
      if (sclk && !prev) cnt++;
      prev = sclk;
    end
    check("rise_wait", 32'(cnt), 32'(n));
  endtask

  task automatic check_last(input logic [23:0] f);
    bit rd = (f[23:16] == CMD_LED_READ);
    check("rises", 32'(last_rises), rd ? 32 : 24);
    check("mosi_bits", last_cap, rd ? {f, 8'h00} : {8'h00, f});
    check("cs_low", 32'(last_low), rd ? 196 : 148);
  endtask

  task automatic run_frame(input logic [23:0] f, input logic [7:0] r, input logic [7:0] exp_ofr);
    int d0 = done_cnt;
    resp = r;
    start_frame(f);
    wait_done(exp_ofr);
    check_last(f);
    check("done_cnt", 32'(done_cnt - d0), 1);
  endtask

  initial begin
    logic [23:0] fa, fb, fc;
    bit          low_seen;
    int          d0;

    rst     = 1'b1;
    i_valid = 1'b0;
    i_frame = '0;

    repeat (5) @(posedge sysclk);
    @(negedge sysclk);
    check("rst_cs", 32'(cs), 1);
    check("rst_sclk", 32'(sclk), 0);
    check("rst_mosi", 32'(mosi), 0);
    check("rst_ready", 32'(o_ready), 0);
    check("rst_done", 32'(o_done), 0);
    check("rst_oframe", 32'(o_frame), 0);
    rst = 1'b0;

    repeat (3) @(negedge sysclk);
    check("gap_ready", 32'(o_ready), 0);
    @(negedge sysclk);
    check("idle_ready", 32'(o_ready), 1);
    check("idle_rises", 32'(rises_total), 0);

    // Write frame, then reads with two different response patterns, then a write.
    run_frame({CMD_LED_SET, 8'h00, 8'h14}, 8'h00, 8'h00);
    run_frame({CMD_LED_READ, 8'h07, 8'h0C}, 8'h01, 8'h01);
    run_frame({CMD_LED_READ, 8'h03, PAYLOAD_NONE}, 8'hA5, 8'hA5);
    run_frame({CMD_LED_SET, ADDR_NONE, 8'hC3}, 8'h00, 8'hA5);

    // Back-to-back with i_valid held; i_frame changes right after acceptance.
    fa = {CMD_LED_SET, 8'h01, 8'hFF};
    fb = {CMD_LED_SET, 8'h02, 8'h80};
    resp = 8'h00;
    low_seen = 1'b0;
    for (int i = 0; i < 50 && !o_ready; i++) @(negedge sysclk);
    i_frame = fa;
    i_valid = 1'b1;
    @(negedge sysclk);
    check("b2b_lat_cs", 32'(cs), 0);
    i_frame = fb;
    wait_done(8'hA5);
    check_last(fa);
    for (int i = 0; i < 20 && !low_seen; i++) begin
      @(negedge sysclk);
      low_seen = !cs;
    end
    i_valid = 1'b0;
    check("b2b_accept", 32'(low_seen), 1);
    wait_done(8'hA5);
    check_last(fb);
    check("b2b_gap", 32'(last_gap), 5);

    // Reset after the 10th sclk rise; mosi is 1 at that point.
    d0 = done_cnt;
    start_frame({CMD_LED_SET, 8'hFF, 8'h55});
    wait_rises(10);
    check("pre_rst_mosi", 32'(mosi), 1);
    rst = 1'b1;
    @(negedge sysclk);
    check("mid_rst_cs", 32'(cs), 1);
    check("mid_rst_sclk", 32'(sclk), 0);
    check("mid_rst_mosi", 32'(mosi), 0);
    check("mid_rst_done", 32'(o_done), 0);
    check("mid_rst_oframe", 32'(o_frame), 0);
    rst = 1'b0;
    repeat (10) @(negedge sysclk);
    check("mid_rst_nodone", 32'(done_cnt - d0), 0);
    run_frame({CMD_LED_READ, 8'h09, 8'h00}, 8'h3C, 8'h3C);

    // A request pulsed during SHIFT must not disturb the frame in flight.
    fc = {CMD_LED_SET, 8'h05, 8'hA5};
    d0 = done_cnt;
    resp = 8'hFF;
    start_frame(fc);
    wait_rises(5);
    i_frame = {CMD_LED_READ, 8'hFF, 8'hFF};
    i_valid = 1'b1;
    @(negedge sysclk);
    i_valid = 1'b0;
    wait_done(8'h3C);
    check_last(fc);
    repeat (12) @(negedge sysclk);
    check("ignored_cs", 32'(cs), 1);
    check("ignored_done", 32'(done_cnt - d0), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
